led_bitplane_sequencer: RTL and testbench
=========================================

# led_bitplane_sequencer

Drives the LED strand during calibration by streaming one binary bitplane of every LED's ID per step. LED i shows ON_COLOR when bit p of its ID (i+1) is set, otherwise off. The block sits directly upstream of `calibration_fsm_w_accum`:
- it consumes the same `increment_id` button;
- it produces `displayed_frame_valid` once the strand has latched the new pattern.

Planes go MSB-first, so the shift-accumulate RAM ends up holding each pixel's LED ID. ID 0 is reserved for "no LED".

## Interface
Parameters:
- NUM_LEDS, 50, LEDs on the strand; must satisfy NUM_LEDS < 2^LED_ADDRESS_WIDTH.
- LED_ADDRESS_WIDTH, 10, ID width, which is also the number of planes.
- ON_COLOR, 24'hFFFFFF, GRB colour for a lit LED.
- LATCH_CYCLES, 7000, strand reset/latch time after the last colour.

Ports (reset rst, synchronous, active-high; clock clk_pixel):
- clk_pixel  in  1  pixel clock
- rst  in  1  synchronous active-high reset
- increment_id  in  1  level button; only rising edges act
- color_out  out  24  colour for LED led_index_out
- color_valid_out  out  1  colour offered to the strand driver
- color_ready_in  in  1  driver accepts; transfer happens when valid&&ready
- led_index_out  out  $clog2(NUM_LEDS)  index of the offered LED
- displayed_frame_valid  out  1  the current plane is latched and showing
- plane_out  out  $clog2(LED_ADDRESS_WIDTH)  plane currently streamed or shown
- calib_done_out  out  1  all planes have been shown; sticky until the next start

## Operation
- Edge detect: inc_edge = increment_id && !old_increment_id, with old_increment_id registered every cycle.
- Colour rule: color_out = bit plane_out of (led_index_out+1) ? ON_COLOR : 0. The ID is computed at LED_ADDRESS_WIDTH+1 bits, then the bit is selected.
- States:
  - IDLE: on inc_edge, plane = LED_ADDRESS_WIDTH-1, idx = 0, calib_done_out = 0, go to STREAM.
  - STREAM: color_valid_out=1. On handshake: if idx==NUM_LEDS-1 then latch_cnt=0 and go to LATCH, else idx+1.
  - LATCH: latch_cnt counts up. At LATCH_CYCLES-1 go to SHOWN.
  - SHOWN: displayed_frame_valid=1. On inc_edge:
    - if plane==0: calib_done_out=1, plane=0, go to IDLE;
    - else plane-1, idx=0, go to STREAM.
- inc_edge in STREAM or LATCH is ignored and is not queued.
- color_out, led_index_out and color_valid_out are registered.
- Outputs must stay stable while valid && !ready.

## Timing
- Reset values:
  - state IDLE;
  - color_out 0, color_valid_out 0, led_index_out 0;
  - displayed_frame_valid 0, plane_out 0, calib_done_out 0;
  - old_increment_id 0.
- An increment_id rise at cycle t is detected at t+1. color_valid_out is high from t+2.
- With color_ready_in held high, streaming a plane takes NUM_LEDS cycles.
- displayed_frame_valid rises exactly LATCH_CYCLES cycles after the cycle of the last handshake.
- displayed_frame_valid falls the cycle after inc_edge is detected in SHOWN.
- displayed_frame_valid is never high while color_valid_out is high.
- Backpressure: idx and colour hold indefinitely while ready=0. There is no timeout.
- Reset mid-stream: the next cycle returns to IDLE with outputs at their reset values. No partial plane is resumed.
- Simultaneous inc_edge and last handshake in STREAM: the handshake completes and the edge is dropped.

## Structure
- Shared calibration package holds:
  - the seq_state_t enum (IDLE, STREAM, LATCH, SHOWN);
  - the LED colour width constant of 24.
- One sub-module is natural: `led_id_bit` (combinational). It takes an index and a plane and returns the lit bit. This keeps the ID+1 offset rule in one place, shared with any future decoder.
- No RAM. Counters only.

## Test plan
- NUM_LEDS=5, LED_ADDRESS_WIDTH=3, ready=1, first edge: plane 2 streams colours 0,0,0,ON,ON for IDs 1..5. displayed_frame_valid rises LATCH_CYCLES after the 5th handshake.
- Three further edges, each with valid high in SHOWN:
  - plane 1 pattern 0,ON,ON,0,0;
  - plane 0 pattern ON,0,ON,0,ON;
  - the 4th edge sets calib_done_out=1 and returns to IDLE.
- Backpressure: ready toggled at random. The sequence of (index,colour) must be exactly 0..4 with no duplicates or skips. Outputs stay stable while stalled.
- increment_id pulsed during STREAM and during LATCH: no plane change, and only one SHOWN results.
- rst asserted at the 3rd handshake: all outputs take reset values next cycle. A fresh edge restarts at plane 2 with idx 0.
- increment_id held high for 100 cycles in SHOWN: exactly one plane advance.

Source files
------------

// File: rtl/led_bitplane_sequencer_pkg.sv
// Shared calibration definitions: sequencer state encoding and LED colour width.
package led_bitplane_sequencer_pkg;

  localparam int LED_COLOR_W = 24;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    LATCH  = 2'd2,
    SHOWN  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/led_bitplane_sequencer_id_bit.sv
// led_id_bit: returns bit i_plane of the LED ID (i_index + 1).
// The +1 offset lives here only, since ID 0 means "no LED".
module led_id_bit
  import led_bitplane_sequencer_pkg::*;
#(
  parameter int IDX_W   = 6,
  parameter int PLANE_W = 4,
  parameter int ADDR_W  = 10
) (
  input  logic [IDX_W-1:0]   i_index,
  input  logic [PLANE_W-1:0] i_plane,
  output logic               o_lit
);

  localparam int ID_W = ADDR_W + 1;

  logic [ID_W-1:0] w_id;
  logic [ID_W-1:0] w_shift;

  // Form the ID one bit wider than the address so the +1 never wraps, then select the plane bit.
  always_comb begin
    w_id    = ID_W'(i_index) + ID_W'(1);
    w_shift = w_id >> i_plane;
    o_lit   = w_shift[0];
  end

endmodule

// File: rtl/led_bitplane_sequencer.sv
// Streams one MSB-first bitplane of every LED's ID to the strand driver per
// increment_id press, then waits out the strand latch time and flags the frame as shown.
module led_bitplane_sequencer
  import led_bitplane_sequencer_pkg::*;
#(
  parameter int                     NUM_LEDS          = 50,
  parameter int                     LED_ADDRESS_WIDTH = 10,
  parameter logic [LED_COLOR_W-1:0] ON_COLOR          = 24'hFFFFFF,
  parameter int                     LATCH_CYCLES      = 7000,
  localparam int IDX_W   = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1,
  localparam int PLANE_W = (LED_ADDRESS_WIDTH > 1) ? $clog2(LED_ADDRESS_WIDTH) : 1,
  localparam int CNT_W   = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1
) (
  input  logic                   clk_pixel,
  input  logic                   rst,
  input  logic                   increment_id,
  output logic [LED_COLOR_W-1:0] color_out,
  output logic                   color_valid_out,
  input  logic                   color_ready_in,
  output logic [IDX_W-1:0]       led_index_out,
  output logic                   displayed_frame_valid,
  output logic [PLANE_W-1:0]     plane_out,
  output logic                   calib_done_out
);

  seq_state_t             r_state;
  logic                   r_old_inc;
  logic                   r_inc_edge;
  logic [IDX_W-1:0]       r_idx;
  logic [PLANE_W-1:0]     r_plane;
  logic [LED_COLOR_W-1:0] r_color;
  logic                   r_valid;
  logic                   r_dfv;
  logic                   r_done;
  logic [CNT_W-1:0]       r_latch_cnt;

  logic [IDX_W-1:0]       w_sel_idx;
  logic [PLANE_W-1:0]     w_sel_plane;
  logic                   w_lit;
  logic [LED_COLOR_W-1:0] w_next_color;
  logic                   w_handshake;
  logic                   w_last_led;

  assign color_out             = r_color;
  assign color_valid_out       = r_valid;
  assign led_index_out         = r_idx;
  assign displayed_frame_valid = r_dfv;
  assign plane_out             = r_plane;
  assign calib_done_out        = r_done;

  assign w_handshake = r_valid & color_ready_in;
  assign w_last_led  = (r_idx == IDX_W'(NUM_LEDS - 1));

  // Pick the (index, plane) whose colour gets registered on the next state change.
  always_comb begin
    w_sel_idx   = {IDX_W{1'b0}};
    w_sel_plane = r_plane;
    case (r_state)
      IDLE: begin
        w_sel_idx   = {IDX_W{1'b0}};
        w_sel_plane = PLANE_W'(LED_ADDRESS_WIDTH - 1);
      end
      STREAM: begin
        w_sel_idx   = r_idx + IDX_W'(1);
        w_sel_plane = r_plane;
      end
      SHOWN: begin
        w_sel_idx   = {IDX_W{1'b0}};
        w_sel_plane = r_plane - PLANE_W'(1);
      end
      default: begin
        w_sel_idx   = {IDX_W{1'b0}};
        w_sel_plane = r_plane;
      end
    endcase
  end

  led_id_bit #(
    .IDX_W   (IDX_W),
    .PLANE_W (PLANE_W),
    .ADDR_W  (LED_ADDRESS_WIDTH)
  ) u_led_id_bit (
    .i_index (w_sel_idx),
    .i_plane (w_sel_plane),
    .o_lit   (w_lit)
  );

  // Map the lit bit onto the strand colour.
  always_comb begin
    if (w_lit) begin
      w_next_color = ON_COLOR;
    end else begin
      w_next_color = {LED_COLOR_W{1'b0}};
    end
  end

  // Registered rising-edge detect on the button; edges act one cycle after they are seen.
  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      r_old_inc  <= 1'b0;
      r_inc_edge <= 1'b0;
    end else begin
      r_old_inc  <= increment_id;
      r_inc_edge <= increment_id & ~r_old_inc;
    end
  end

  // Sequencer FSM with all strand-facing outputs registered.
  always_ff @(posedge clk_pixel) begin
    if (rst) begin
      r_state     <= IDLE;
      r_idx       <= {IDX_W{1'b0}};
      r_plane     <= {PLANE_W{1'b0}};
      r_color     <= {LED_COLOR_W{1'b0}};
      r_valid     <= 1'b0;
      r_dfv       <= 1'b0;
      r_done      <= 1'b0;
      r_latch_cnt <= {CNT_W{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          if (r_inc_edge) begin
            r_state <= STREAM;
            r_plane <= w_sel_plane;
            r_idx   <= {IDX_W{1'b0}};
            r_color <= w_next_color;
            r_valid <= 1'b1;
            r_done  <= 1'b0;
          end
        end
        STREAM: begin
          // Index and colour only move on a transfer, so they hold under backpressure.
          if (w_handshake) begin
            if (w_last_led) begin
              r_state     <= LATCH;
              r_valid     <= 1'b0;
              r_latch_cnt <= {CNT_W{1'b0}};
            end else begin
              r_idx   <= w_sel_idx;
              r_color <= w_next_color;
            end
          end
        end
        LATCH: begin
          // Counter starts at 0 the cycle after the last transfer; leaving at LATCH_CYCLES-2
          // makes displayed_frame_valid rise exactly LATCH_CYCLES cycles after that transfer.
          if (r_latch_cnt == CNT_W'(LATCH_CYCLES - 2)) begin
            r_state <= SHOWN;
            r_dfv   <= 1'b1;
          end else begin
            r_latch_cnt <= r_latch_cnt + CNT_W'(1);
          end
        end
        SHOWN: begin
          if (r_inc_edge) begin
            r_dfv <= 1'b0;
            if (r_plane == {PLANE_W{1'b0}}) begin
              r_state <= IDLE;
              r_done  <= 1'b1;
              r_plane <= {PLANE_W{1'b0}};
            end else begin
              r_state <= STREAM;
              r_plane <= w_sel_plane;
              r_idx   <= {IDX_W{1'b0}};
              r_color <= w_next_color;
              r_valid <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_valid <= 1'b0;
          r_dfv   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_bitplane_sequencer.sv
// Directed bench for led_bitplane_sequencer with 5 LEDs, 3 planes and a short latch time.
module tb_led_bitplane_sequencer;

  localparam int          N_LEDS  = 5;
  localparam int          A_W     = 3;
  localparam int          L_CYC   = 8;
  localparam logic [23:0] ON_C    = 24'h12AB34;

  logic        clk_pixel = 1'b0;
  logic        rst;
  logic        increment_id;
  logic [23:0] color_out;
  logic        color_valid_out;
  logic        color_ready_in;
  logic [2:0]  led_index_out;
  logic        displayed_frame_valid;
  logic [1:0]  plane_out;
  logic        calib_done_out;

  int n_tests = 0;
  int n_fail  = 0;

  led_bitplane_sequencer #(
    .NUM_LEDS          (N_LEDS),
    .LED_ADDRESS_WIDTH (A_W),
    .ON_COLOR          (ON_C),
    .LATCH_CYCLES      (L_CYC)
  ) dut (
    .clk_pixel             (clk_pixel),
    .rst                   (rst),
    .increment_id          (increment_id),
    .color_out             (color_out),
    .color_valid_out       (color_valid_out),
    .color_ready_in        (color_ready_in),
    .led_index_out         (led_index_out),
    .displayed_frame_valid (displayed_frame_valid),
    .plane_out             (plane_out),
    .calib_done_out        (calib_done_out)
  );

  always #5 clk_pixel = ~clk_pixel;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_pixel);
    #1;
  endtask

  // Rise increment_id for one cycle; on return valid should be up if a plane started.
  task automatic press(input logic exp_dfv_t1);
    increment_id = 1'b1;
    step();
    check_eq("press_t1_valid", 32'(color_valid_out), 32'd0);
    check_eq("press_t1_dfv", 32'(displayed_frame_valid), 32'(exp_dfv_t1));
    increment_id = 1'b0;
    step();
  endtask

  // Consume one plane (5 transfers), then check displayed_frame_valid timing.
  task automatic stream_plane(input int plane, input logic [4:0] pat, input bit bp, input bit poke);
    int          k;
    int          cyc;
    bit          held;
    logic [2:0]  h_idx;
    logic [23:0] h_col;
    logic [23:0] exp_c;
    k   = 0;
    cyc = 0;
    while (k < N_LEDS && cyc < 200) begin
      if (bp) color_ready_in = 1'($urandom_range(0, 1));
      else    color_ready_in = 1'b1;
      increment_id = (poke && k == 2) ? 1'b1 : 1'b0;
      held = 1'b0;
      if (color_valid_out && color_ready_in) begin
        exp_c = pat[k] ? ON_C : 24'h000000;
        check_eq("hs_idx", 32'(led_index_out), 32'(k));
        check_eq("hs_color", 32'(color_out), 32'(exp_c));
        check_eq("hs_plane", 32'(plane_out), 32'(plane));
        check_eq("hs_dfv", 32'(displayed_frame_valid), 32'd0);
        k++;
      end else if (color_valid_out) begin
        held  = 1'b1;
        h_idx = led_index_out;
        h_col = color_out;
      end
      step();
      cyc++;
      if (held) begin
        check_eq("stall_idx", 32'(led_index_out), 32'(h_idx));
        check_eq("stall_color", 32'(color_out), 32'(h_col));
      end
    end
    increment_id   = 1'b0;
    color_ready_in = 1'b1;
    if (k < N_LEDS) check_eq("stream_timeout", 32'(k), 32'(N_LEDS));
    check_eq("post_valid", 32'(color_valid_out), 32'd0);
    for (int j = 2; j <= L_CYC; j++) begin
      increment_id = (poke && j == 3) ? 1'b1 : 1'b0;
      step();
      if (j == L_CYC - 1) check_eq("dfv_early", 32'(displayed_frame_valid), 32'd0);
    end
    increment_id = 1'b0;
    check_eq("dfv_rise", 32'(displayed_frame_valid), 32'd1);
    check_eq("shown_plane", 32'(plane_out), 32'(plane));
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_valid"}, 32'(color_valid_out), 32'd0);
    check_eq({tag, "_color"}, 32'(color_out), 32'd0);
    check_eq({tag, "_idx"}, 32'(led_index_out), 32'd0);
    check_eq({tag, "_dfv"}, 32'(displayed_frame_valid), 32'd0);
    check_eq({tag, "_plane"}, 32'(plane_out), 32'd0);
    check_eq({tag, "_done"}, 32'(calib_done_out), 32'd0);
  endtask

  initial begin
    int         k;
    int         cyc;
    int         changes;
    logic [1:0] last_plane;

    rst            = 1'b1;
    increment_id   = 1'b0;
    color_ready_in = 1'b1;
    repeat (3) step();
    check_reset_outputs("rst");
    rst = 1'b0;
    step();
    check_reset_outputs("idle");

    // Plane 2, ready high: IDs 1..5 bit 2 -> 0,0,0,ON,ON.
    press(1'b0);
    check_eq("start_valid", 32'(color_valid_out), 32'd1);
    check_eq("start_plane", 32'(plane_out), 32'd2);
    stream_plane(2, 5'b11000, 1'b0, 1'b0);

    // Plane 1 under random backpressure: 0,ON,ON,0,0.
    press(1'b1);
    check_eq("dfv_fall", 32'(displayed_frame_valid), 32'd0);
    check_eq("p1_valid", 32'(color_valid_out), 32'd1);
    stream_plane(1, 5'b00110, 1'b1, 1'b0);

    // Plane 0 with stray pulses in STREAM and LATCH: ON,0,ON,0,ON.
    press(1'b1);
    stream_plane(0, 5'b10101, 1'b0, 1'b1);
    repeat (5) step();
    check_eq("no_queue_plane", 32'(plane_out), 32'd0);
    check_eq("no_queue_dfv", 32'(displayed_frame_valid), 32'd1);
    check_eq("no_queue_valid", 32'(color_valid_out), 32'd0);

    // Final press after plane 0 ends calibration.
    press(1'b1);
    check_eq("done_set", 32'(calib_done_out), 32'd1);
    check_eq("done_dfv", 32'(displayed_frame_valid), 32'd0);
    check_eq("done_valid", 32'(color_valid_out), 32'd0);
    repeat (3) step();
    check_eq("done_sticky", 32'(calib_done_out), 32'd1);

    // Restart, then reset at the 3rd transfer.
    press(1'b0);
    check_eq("restart_done_clr", 32'(calib_done_out), 32'd0);
    check_eq("restart_plane", 32'(plane_out), 32'd2);
    k   = 0;
    cyc = 0;
    while (k < 2 && cyc < 50) begin
      if (color_valid_out && color_ready_in) k++;
      step();
      cyc++;
    end
    check_eq("pre_rst_idx", 32'(led_index_out), 32'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outputs("midrst");
    step();
    check_eq("midrst_idle_valid", 32'(color_valid_out), 32'd0);
    press(1'b0);
    check_eq("fresh_plane", 32'(plane_out), 32'd2);
    check_eq("fresh_idx", 32'(led_index_out), 32'd0);
    check_eq("fresh_color", 32'(color_out), 32'd0);
    stream_plane(2, 5'b11000, 1'b0, 1'b0);

    // Button held for 100 cycles in SHOWN: one plane advance only.
    increment_id = 1'b1;
    changes      = 0;
    last_plane   = plane_out;
    for (int i = 0; i < 100; i++) begin
      step();
      if (plane_out != last_plane) changes++;
      last_plane = plane_out;
    end
    increment_id = 1'b0;
    repeat (3) step();
    check_eq("hold_advances", 32'(changes), 32'd1);
    check_eq("hold_plane", 32'(plane_out), 32'd1);
    check_eq("hold_dfv", 32'(displayed_frame_valid), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
